// File: rtl/fetch_inst_queue_if.sv
// Fetch-to-decode handshake bundle: enqueue side from fetch, dequeue side to decode.
// master = fetch/decode environment, slave = the queue itself.
interface fetch_inst_queue_if;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_inst;
  logic [31:0] enq_pc;
  logic [31:0] enq_pc_next;
  logic        enq_br_pred;

  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic [31:0] deq_pc_next;
  logic        deq_br_pred;

  modport master (
    output enq_valid, enq_inst, enq_pc, enq_pc_next, enq_br_pred, deq_ready,
    input  enq_ready, deq_valid, deq_inst, deq_pc, deq_pc_next, deq_br_pred
  );

  modport slave (
    input  enq_valid, enq_inst, enq_pc, enq_pc_next, enq_br_pred, deq_ready,
    output enq_ready, deq_valid, deq_inst, deq_pc, deq_pc_next, deq_br_pred
  );
endinterface

// File: rtl/fetch_inst_queue.sv
// Circular instruction queue between fetch and decode; one enq and one deq per
// cycle, single-cycle flush, full/empty derived from the occupancy counter.
module fetch_inst_queue #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  fetch_inst_queue_if.slave   q,
  output logic [PTR_W:0]      count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]      inst_mem    [DEPTH];
  logic [31:0]      pc_mem      [DEPTH];
  logic [31:0]      pc_next_mem [DEPTH];
  logic             br_pred_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             enq_fire;
  logic             deq_fire;

  assign q.enq_ready = (count != FULL_COUNT);
  assign q.deq_valid = (count != '0);
  assign enq_fire    = q.enq_valid && q.enq_ready && !flush;
  assign deq_fire    = q.deq_valid && q.deq_ready;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) tail <= tail + 1'b1;
      if (deq_fire) head <= head + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      inst_mem[tail]    <= q.enq_inst;
      pc_mem[tail]      <= q.enq_pc;
      pc_next_mem[tail] <= q.enq_pc_next;
      br_pred_mem[tail] <= q.enq_br_pred;
    end
  end

  // Head outputs are forced to zero when empty so decode never sees stale data.
  always_comb begin
    q.deq_inst    = '0;
    q.deq_pc      = '0;
    q.deq_pc_next = '0;
    q.deq_br_pred = 1'b0;
    if (q.deq_valid) begin
      q.deq_inst    = inst_mem[head];
      q.deq_pc      = pc_mem[head];
      q.deq_pc_next = pc_next_mem[head];
      q.deq_br_pred = br_pred_mem[head];
    end
  end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Randomised and directed checks of fetch_inst_queue against a queue-based model.
module tb_fetch_inst_queue;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        br_pred;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] count;

  fetch_inst_queue_if bus();

  fetch_inst_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .q     (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  entry_t model_q[$];
  int     vectors     = 0;
  int     miscompares = 0;

  function automatic logic [102:0] observed();
    return {bus.deq_valid, bus.enq_ready, count,
            bus.deq_inst, bus.deq_pc, bus.deq_pc_next, bus.deq_br_pred};
  endfunction

  function automatic logic [102:0] expected();
    entry_t h;
    h = '0;
    if (model_q.size() != 0) h = model_q[0];
    return {model_q.size() != 0, model_q.size() != DEPTH, 4'(model_q.size()), h};
  endfunction

  function automatic entry_t mk(input logic [31:0] pc);
    entry_t e;
    e.inst    = $urandom;
    e.pc      = pc;
    e.pc_next = pc + 32'd4;
    e.br_pred = 1'($urandom_range(0, 1));
    return e;
  endfunction

  task automatic drive(input logic v, input entry_t e, input logic r, input logic f);
    bus.enq_valid   = v;
    bus.enq_inst    = e.inst;
    bus.enq_pc      = e.pc;
    bus.enq_pc_next = e.pc_next;
    bus.enq_br_pred = e.br_pred;
    bus.deq_ready   = r;
    flush           = f;
  endtask

  // Model update at the rising edge, then return to the falling edge for checking.
  task automatic tick();
    bit     do_enq, do_deq;
    entry_t e;
    @(posedge clk);
    if (!rst || flush) begin
      model_q.delete();
    end else begin
      do_deq = (model_q.size() != 0) && bus.deq_ready;
      do_enq = (model_q.size() != DEPTH) && bus.enq_valid;
      e = {bus.enq_inst, bus.enq_pc, bus.enq_pc_next, bus.enq_br_pred};
      if (do_deq) void'(model_q.pop_front());
      if (do_enq) model_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic clear_queue();
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, mk(32'h0000_0100), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({count, bus.deq_valid, bus.deq_inst, bus.enq_ready} !== {4'd0, 1'b0, 32'd0, 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL reset_idle cyc%0d: got cnt=%0d dv=%b inst=%h er=%b, want cnt=0 dv=0 inst=0 er=1",
                 i, count, bus.deq_valid, bus.deq_inst, bus.enq_ready);
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  task automatic test_single_pass();
    entry_t e;
    e = {32'h0050_0093, 32'h0000_1000, 32'h0000_1004, 1'b0};
    drive(1'b1, e, 1'b0, 1'b0);
    vectors++;
    if (bus.deq_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_no_bypass: got dv=%b want 0", bus.deq_valid);
    end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if ({bus.deq_valid, bus.deq_inst, bus.deq_pc, bus.deq_pc_next, bus.deq_br_pred} !== {1'b1, e}) begin
      miscompares++;
      $display("[TB] FAIL single_visible: got dv=%b %h %h %h %b want 1 %h %h %h %b",
               bus.deq_valid, bus.deq_inst, bus.deq_pc, bus.deq_pc_next, bus.deq_br_pred,
               e.inst, e.pc, e.pc_next, e.br_pred);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    vectors++;
    if ({count, bus.deq_valid} !== {4'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL single_drained: got cnt=%0d dv=%b want cnt=0 dv=0", count, bus.deq_valid);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, mk(32'h1000 + 32'(4 * i)), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, mk(32'h0000_DEAD), 1'b0, 1'b0);
    vectors++;
    if ({count, bus.enq_ready} !== {4'd8, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL fill_full: got cnt=%0d er=%b want cnt=8 er=0", count, bus.enq_ready);
    end
    tick();
    vectors++;
    if (count !== 4'd8) begin
      miscompares++;
      $display("[TB] FAIL fill_ninth_dropped: got cnt=%0d want 8", count);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (bus.deq_pc !== 32'h1000 + 32'(4 * i) || observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL fill_order%0d: got pc=%h vec=%h want pc=%h vec=%h",
                 i, bus.deq_pc, observed(), 32'h1000 + 32'(4 * i), expected());
      end
      tick();
    end
    vectors++;
    if ({count, bus.deq_valid} !== {4'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL fill_empty: got cnt=%0d dv=%b want 0 0", count, bus.deq_valid);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(32'h2000 + 32'(4 * i)), 1'b0, 1'b0);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, mk(32'h2000 + 32'(4 * (k + 3))), 1'b1, 1'b0);
      vectors++;
      if (count !== 4'd3 || bus.deq_pc !== 32'h2000 + 32'(4 * k) || observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL wrap%0d: got cnt=%0d pc=%h vec=%h want cnt=3 pc=%h vec=%h",
                 k, count, bus.deq_pc, observed(), 32'h2000 + 32'(4 * k), expected());
      end
      tick();
    end
    clear_queue();
  endtask

  task automatic test_full_deq();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, mk(32'h3000 + 32'(4 * i)), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, mk(32'h0000_BAD0), 1'b1, 1'b0);
    tick();
    vectors++;
    if ({count, bus.enq_ready} !== {4'd7, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL full_deq_count: got cnt=%0d er=%b want cnt=7 er=1", count, bus.enq_ready);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      vectors++;
      if (bus.deq_pc !== 32'h3000 + 32'(4 * i) || observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL full_deq_order%0d: got pc=%h want pc=%h", i, bus.deq_pc,
                 32'h3000 + 32'(4 * i));
      end
      tick();
    end
    vectors++;
    if (count !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL full_deq_dropped: got cnt=%0d want 0", count);
    end
  endtask

  task automatic test_flush();
    entry_t e;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mk(32'h4000 + 32'(4 * i)), 1'b0, 1'b0);
      tick();
    end
    vectors++;
    if (count !== 4'd5) begin
      miscompares++;
      $display("[TB] FAIL flush_pre: got cnt=%0d want 5", count);
    end
    drive(1'b1, mk(32'h5000), 1'b1, 1'b1);
    tick();
    e = {32'h1234_5678, 32'h0000_6000, 32'h0000_7000, 1'b1};
    drive(1'b1, e, 1'b0, 1'b0);
    vectors++;
    if ({count, bus.deq_valid, bus.deq_pc} !== {4'd0, 1'b0, 32'd0}) begin
      miscompares++;
      $display("[TB] FAIL flush_empty: got cnt=%0d dv=%b pc=%h want 0 0 0", count, bus.deq_valid, bus.deq_pc);
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    vectors++;
    if ({bus.deq_valid, bus.deq_inst, bus.deq_pc, bus.deq_pc_next, bus.deq_br_pred, count} !== {1'b1, e, 4'd1}) begin
      miscompares++;
      $display("[TB] FAIL flush_refill: got dv=%b %h %h %h %b cnt=%0d want 1 %h %h %h %b cnt=1",
               bus.deq_valid, bus.deq_inst, bus.deq_pc, bus.deq_pc_next, bus.deq_br_pred, count,
               e.inst, e.pc, e.pc_next, e.br_pred);
    end
    clear_queue();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mk(32'h8000 + 32'(4 * i)), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    model_q.delete();
    #1;
    vectors++;
    if ({count, bus.deq_valid, bus.enq_ready, bus.deq_pc} !== {4'd0, 1'b0, 1'b1, 32'd0}) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got cnt=%0d dv=%b er=%b pc=%h want 0 0 1 0",
               count, bus.deq_valid, bus.enq_ready, bus.deq_pc);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0), mk($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 31) == 0));
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("[TB] FAIL random%0d: got %h want %h", k, observed(), expected());
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_single_pass();
    test_fill();
    test_wrap();
    test_full_deq();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_inst_queue.md
# fetch_inst_queue

Circular FIFO between instruction fetch and the decode stage. Fetch writes one entry per cycle: the instruction word, its PC, predicted next PC and branch-prediction bit. Decode reads one entry per cycle over a valid/ready handshake. The queue absorbs I-cache and decode/dispatch stalls, and empties in one cycle on a pipeline flush (mispredict/redirect).

## Interface
- DEPTH, 8, number of entries; power of two, ≥2
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- flush  input  1  discard all entries this cycle
- enq_valid  input  1  fetch presents an entry
- enq_ready  output  1  queue accepts an entry (= not full)
- enq_inst  input  32  instruction word
- enq_pc  input  32  PC of instruction
- enq_pc_next  input  32  predicted next PC
- enq_br_pred  input  1  predicted-taken bit
- deq_valid  output  1  head entry valid (= not empty)
- deq_ready  input  1  decode consumes head this cycle
- deq_inst  output  32  head instruction (to decoder inst)
- deq_pc  output  32  head PC (to decoder pc)
- deq_pc_next  output  32  head predicted next PC (to decoder pc_next)
- deq_br_pred  output  1  head prediction bit (to decoder br_pred)
- count  output  PTR_W+1  occupied entries, 0..DEPTH

## Operation
- Storage: DEPTH entries of {inst, pc, pc_next, br_pred}; head and tail pointers of PTR_W bits; occupancy counter of PTR_W+1 bits.
- Enqueue fires when enq_valid && enq_ready: write entry at tail, tail += 1 mod DEPTH.
- Dequeue fires when deq_valid && deq_ready: head += 1 mod DEPTH.
- count next = count + enq_fire − deq_fire; both firing leaves count unchanged.
- enq_ready = (count != DEPTH). When full, no enqueue that cycle even if a dequeue fires; there is no same-cycle full pass-through.
- deq_valid = (count != 0). No empty bypass: an entry written in cycle N is first visible on deq_* in cycle N+1.
- deq_* are combinational reads of the head entry. When count == 0, deq_inst/pc/pc_next/br_pred drive 0 so the decoder never sees stale data.
- Flush has priority over everything. On a flush cycle:
  - head, tail and count go to 0 at the next edge;
  - a simultaneous enqueue is dropped (not written);
  - a simultaneous dequeue is irrelevant.
- Flush does not gate enq_ready or deq_valid in the flush cycle itself; both are pure functions of count.
- Pointer wrap: DEPTH−1 + 1 → 0. Full/empty are taken from count, never from pointer equality.
- Entry storage needs no reset; only pointers and count reset.

## Timing
- Reset (rst = 0, async): head = tail = 0, count = 0, enq_ready = 1, deq_valid = 0, deq_* = 0. These take effect immediately, independent of clk.
- Reset deassertion is synchronised externally; the first enqueue may fire on the first rising edge with rst = 1.
- Reset mid-operation discards all contents exactly like flush, but asynchronously.
- Latency enqueue→deq_valid: 1 cycle. Throughput: 1 enq + 1 deq per cycle when 0 < count < DEPTH.
- enq_ready and deq_valid depend only on registered state. There is no combinational path from deq_ready to enq_ready or from enq_valid to deq_valid.

## Test plan
- Reset/idle: hold rst = 0 for 3 cycles with enq_valid = 1 → count = 0, deq_valid = 0, deq_inst = 0, enq_ready = 1. Release reset.
- Single pass: enq inst = 0x00500093, pc = 0x1000, pc_next = 0x1004, br_pred = 0 at cycle N.
  - Cycle N+1: deq_valid = 1 with identical fields.
  - Assert deq_ready → count returns to 0 at N+2.
- Fill/full: DEPTH = 8, enqueue 8 entries with deq_ready = 0.
  - count = 8, enq_ready = 0.
  - A 9th enq_valid is not written.
  - Then dequeue all 8 → PCs come out in order 0x1000, 0x1004, … 0x101C.
- Wrap-around: continuous simultaneous enq/deq for 20 cycles at count = 3.
  - count stays 3.
  - Output PC sequence is strictly +4 across the pointer wrap.
- Full with simultaneous deq: count = 8, enq_valid = 1, deq_ready = 1 → next count = 7; the enqueued entry is dropped (enq_ready was 0).
- Flush: count = 5, flush = 1 together with enq_valid = 1 and deq_ready = 1 → next cycle count = 0, deq_valid = 0. A following enqueue appears on deq_* one cycle later with the correct data.
